// File: rtl/pipe_stage_reg_pkg.sv
// Shared CPU package for the pipeline stage register slice.
// Holds the default payload widths, the reset PC, the NOP encoding,
// the slot operation codes and a small occupancy helper.
package pipe_stage_reg_pkg;

  localparam int unsigned CPU_INSTR_W  = 32;
  localparam int unsigned CPU_PC_W     = 32;
  localparam int unsigned CPU_META_W   = 8;
  localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] CPU_NOP      = 32'h0000_0000;

  // Operation applied to a pipe_slot on the next rising edge.
  typedef enum logic [1:0] {
    SLOT_HOLD,       // keep valid and payload
    SLOT_LOAD,       // valid <= 1, payload <= d
    SLOT_SET_EMPTY,  // valid <= 0, payload <= d (bubble carrying a PC)
    SLOT_CLEAR       // valid <= 0, payload kept
  } slot_op_e;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one valid bit plus a payload register.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   op           - slot operation for this edge (hold/load/set-empty/clear)
//   d            - payload to load
//   q_valid, q   - registered valid flag and payload
module pipe_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned     W          = 8,
  parameter logic [W-1:0]    RESET_DATA = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  slot_op_e       op,
  input  logic [W-1:0]   d,
  output logic           q_valid,
  output logic [W-1:0]   q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= 1'b0;
      q       <= RESET_DATA;
    end else begin
      case (op)
        SLOT_LOAD: begin
          q_valid <= 1'b1;
          q       <= d;
        end
        SLOT_SET_EMPTY: begin
          q_valid <= 1'b0;
          q       <= d;
        end
        SLOT_CLEAR: q_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register carrying an
// instruction, its PC and side-band bits. SKID=0 gives a single slot with
// a combinational in_ready; SKID=1 adds a skid slot so in_ready is a pure
// function of registered state.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   in_valid/in_ready, in_instr/pc/meta - upstream handshake and payload
//   out_valid/out_ready, out_instr/pc/meta - downstream handshake and payload
//   flush, flush_pc                     - kill all contents, bubble keeps flush_pc
//   occupancy                           - number of held entries (0..2)
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned     INSTR_W  = CPU_INSTR_W,
  parameter int unsigned     PC_W     = CPU_PC_W,
  parameter int unsigned     META_W   = CPU_META_W,
  parameter int unsigned     SKID     = 1,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(CPU_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [META_W-1:0]  in_meta,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [META_W-1:0]  out_meta,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  output logic [1:0]         occupancy
);

  localparam int unsigned PW = PC_W + INSTR_W + META_W;
  localparam logic [PW-1:0] MAIN_RST = {RESET_PC, INSTR_W'(CPU_NOP), META_W'(0)};

  logic [PW-1:0] in_payload;
  logic [PW-1:0] flush_payload;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          main_valid;
  logic          skid_valid;
  logic          main_free;
  logic          in_fire;
  slot_op_e      main_op;
  slot_op_e      skid_op;

  assign in_payload    = {in_pc, in_instr, in_meta};
  assign flush_payload = {flush_pc, INSTR_W'(CPU_NOP), META_W'(0)};
  assign main_free     = !main_valid || out_ready;
  assign in_fire       = in_valid && in_ready;

  // Main slot refills from skid first to preserve order; an accepted input
  // can only reach skid while main is held, since in_ready is low whenever
  // skid is occupied.
  always_comb begin
    main_op = SLOT_HOLD;
    main_d  = in_payload;
    skid_op = SLOT_HOLD;
    if (flush) begin
      main_op = SLOT_SET_EMPTY;
      main_d  = flush_payload;
      skid_op = SLOT_CLEAR;
    end else if (main_free) begin
      if (skid_valid) begin
        main_op = SLOT_LOAD;
        main_d  = skid_q;
        skid_op = SLOT_CLEAR;
      end else if (in_fire) begin
        main_op = SLOT_LOAD;
      end else if (main_valid) begin
        main_op = SLOT_CLEAR;
      end
    end else if (in_fire) begin
      skid_op = SLOT_LOAD;
    end
  end

  pipe_slot #(
    .W          (PW),
    .RESET_DATA (MAIN_RST)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .op      (main_op),
    .d       (main_d),
    .q_valid (main_valid),
    .q       (main_q)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(
      .W          (PW),
      .RESET_DATA ('0)
    ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .op      (skid_op),
      .d       (in_payload),
      .q_valid (skid_valid),
      .q       (skid_q)
    );
    assign in_ready = !skid_valid;
  end else begin : g_single
    logic unused_skid_op;
    assign unused_skid_op = (skid_op == SLOT_LOAD);
    assign skid_valid     = 1'b0;
    assign skid_q         = '0;
    assign in_ready       = main_free;
  end

  // The PC field stays visible while empty; instruction and side-band
  // read as NOP/zero whenever nothing valid is presented.
  assign out_valid = main_valid;
  assign out_pc    = main_q[PW-1 -: PC_W];
  assign out_instr = main_valid ? main_q[META_W +: INSTR_W] : INSTR_W'(CPU_NOP);
  assign out_meta  = main_valid ? main_q[META_W-1:0] : '0;
  assign occupancy = occ_count(main_valid, skid_valid);

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL take parameter INSTR_W, default 32, instruction payload width.
REQ-002 SHALL take parameter PC_W, default 32, PC payload width.
REQ-003 SHALL take parameter META_W, default 8, side-band bits (exc code, BD flag, etc.).
REQ-004 SHALL take parameter SKID, default 1; 0 = single slot, 1 = two-slot skid buffer.
REQ-005 SHALL take parameter RESET_PC, default 32'h0000_3000, PC value loaded at reset.
REQ-006 Ports SHALL be, in order:
- clk  input  1  clock; reset, synchronous, active-high; clock clk.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage accepts this cycle.
- in_instr  input  INSTR_W  upstream instruction.
- in_pc  input  PC_W  upstream PC.
- in_meta  input  META_W  upstream side-band.
- out_valid  output  1  stage presents a valid instruction.
- out_ready  input  1  downstream accepts this cycle.
- out_instr  output  INSTR_W  presented instruction.
- out_pc  output  PC_W  presented PC.
- out_meta  output  META_W  presented side-band.
- flush  input  1  discard all contents (exception / branch kill).
- flush_pc  input  PC_W  PC retained in the bubble after a flush.
- occupancy  output  2  entries held (0..2).

Function
REQ-007 Transfer in SHALL occur on a rising edge with in_valid && in_ready; transfer out on a rising edge with out_valid && out_ready.
REQ-008 When SKID=0: in_ready SHALL equal !out_valid || out_ready (combinational); occupancy SHALL never exceed 1.
REQ-009 When SKID=1: in_ready SHALL be registered and equal !skid_valid; there SHALL be no combinational path from out_ready to in_ready.
REQ-010 SKID=1, main empty or main consumed: accepted input SHALL load main; otherwise (main held, out_ready=0) it SHALL load skid.
REQ-011 SKID=1, main consumed while skid full: skid SHALL move to main in the same edge; in_ready SHALL rise the next cycle.
REQ-012 Outputs SHALL present main-slot contents; latency in to out SHALL be exactly 1 cycle when the stage is empty.
REQ-013 Whenever out_valid=0, out_instr SHALL be 0 (NOP) and out_meta SHALL be 0; out_pc SHALL hold its last loaded value.
REQ-014 Order SHALL be strictly FIFO; no entry SHALL be duplicated or dropped except by flush/reset.
REQ-015 Simultaneous in and out transfer SHALL leave occupancy unchanged.
REQ-016 flush SHALL have priority over every transfer: next cycle occupancy=0, out_valid=0, out_instr=0, out_meta=0, out_pc=flush_pc; a same-cycle input SHALL be discarded.
REQ-017 in_ready during a flush cycle SHALL follow REQ-008/009 unchanged; the next cycle in_ready SHALL be 1.
REQ-018 occupancy SHALL be main_valid + skid_valid, registered-consistent with slot state.

Reset
REQ-019 reset SHALL have priority over flush: next cycle out_valid=0, out_instr=0, out_meta=0, out_pc=RESET_PC, occupancy=0, in_ready=1.
REQ-020 Reset mid-operation SHALL discard both slots with no transfer out on that edge.

Structure
REQ-021 RESET_PC, the NOP encoding (32'h0) and the default widths SHALL live in the shared CPU package.
REQ-022 One sub-module, pipe_slot (valid + payload register with load/clear), SHALL be instantiated once (SKID=0) or twice (SKID=1).

Verification
REQ-023 Reset then idle -> out_valid=0, out_pc=32'h3000, out_instr=0, in_ready=1.
REQ-024 SKID=1, out_ready=0, push 0x24010001@0x3000 and 0x24020002@0x3004 -> occupancy=2, in_ready=0, out_pc=0x3000; raise out_ready -> 0x3000 then 0x3004 emitted in order.
REQ-025 Streaming push every cycle with out_ready=1 -> one instruction out per cycle, latency 1, occupancy=1.
REQ-026 occupancy=2, flush with flush_pc=0x3008 and in_valid=1 -> next cycle occupancy=0, out_valid=0, out_pc=0x3008, pushed word never emitted.
REQ-027 flush and reset together -> out_pc=0x3000 (reset wins).
REQ-028 SKID=0, out_ready=0 with main full -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
